// File: rtl/ddr2_bank_timing_checker.sv
// ddr2_bank_timing_checker: passive DDR2 per-bank open-row and tRCD/tRAS/tRP monitor with error flags.
// Optional DDR2_BANK_CHK_FATAL_EN: print time/code/bank/row and stop simulation on each error.
module ddr2_bank_timing_checker #(
  parameter int NUM_BANKS = 4,
  parameter int ROW_W     = 13,
  parameter int TRP_MIN   = 4,
  parameter int TRCD_MIN  = 3,
  parameter int TRAS_MIN  = 9,
  parameter int CNT_W     = 8,
  localparam int BA_W     = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke_pad,
  input  logic                 csbar_pad,
  input  logic                 rasbar_pad,
  input  logic                 casbar_pad,
  input  logic                 webar_pad,
  input  logic [BA_W-1:0]      ba_pad,
  input  logic [ROW_W-1:0]     a_pad,
  output logic [NUM_BANKS-1:0] bank_open_vec,
  output logic                 err_valid,
  output logic [2:0]           err_code,
  output logic [BA_W-1:0]      err_bank,
  output logic [15:0]          err_count
);
  logic [NUM_BANKS-1:0] open_q, open_d, hit, act_b, pre_b, rw_b, tras_v, trp_short, trcd_short;
  logic [CNT_W-1:0] since_act [NUM_BANKS];
  logic [CNT_W-1:0] since_pre [NUM_BANKS];
  logic cmd_en, is_act, is_pre, is_rw, pre_all;
  logic act_open, act_trp, rw_closed, rw_trcd, tras_any, err_now;
  logic [2:0] code_d;
  logic [BA_W-1:0] low_idx, bank_d;
  always_comb begin
    cmd_en  = cke_pad & ~csbar_pad;
    is_act  = cmd_en & ~rasbar_pad & casbar_pad & webar_pad;
    is_pre  = cmd_en & ~rasbar_pad & casbar_pad & ~webar_pad;
    is_rw   = cmd_en & rasbar_pad & ~casbar_pad;
    pre_all = is_pre & a_pad[10];
  end
  // pre_b only marks banks that actually close, so PRE to an idle bank leaves since_pre alone
  always_comb begin
    hit = '0;
    trp_short = '0;
    trcd_short = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      hit[b]        = ba_pad == BA_W'(b);
      trp_short[b]  = since_pre[b] < CNT_W'(TRP_MIN);
      trcd_short[b] = since_act[b] < CNT_W'(TRCD_MIN);
      tras_v[b]     = 1'b0;
    end
    act_b = {NUM_BANKS{is_act}} & hit;
    rw_b  = {NUM_BANKS{is_rw}} & hit;
    pre_b = {NUM_BANKS{is_pre}} & (hit | {NUM_BANKS{pre_all}}) & open_q;
    for (int b = 0; b < NUM_BANKS; b++)
      tras_v[b] = pre_b[b] & (since_act[b] < CNT_W'(TRAS_MIN));
  end
  always_comb begin
    low_idx = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--)
      if (tras_v[b]) low_idx = BA_W'(b);
  end
  always_comb begin
    act_open  = |(act_b & open_q);
    act_trp   = |(act_b & ~open_q & trp_short);
    rw_closed = |(rw_b & ~open_q);
    rw_trcd   = |(rw_b & open_q & trcd_short);
    tras_any  = |tras_v;
    err_now   = act_open | act_trp | rw_closed | rw_trcd | tras_any;
    code_d    = act_open ? 3'd1 : act_trp ? 3'd2 : rw_closed ? 3'd4 : rw_trcd ? 3'd3 : tras_any ? 3'd5 : 3'd0;
    bank_d    = is_pre ? low_idx : ba_pad;
    open_d    = (open_q | act_b) & ~pre_b;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      open_q    <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
      err_bank  <= '0;
      err_count <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        since_act[b] <= '1;
        since_pre[b] <= '1;
      end
    end else begin
      open_q    <= open_d;
      err_valid <= err_now;
      if (err_now) begin
        err_code <= code_d;
        err_bank <= bank_d;
      end
      if (err_now && !(&err_count)) err_count <= err_count + 16'd1;
      for (int b = 0; b < NUM_BANKS; b++) begin
        since_act[b] <= act_b[b] ? CNT_W'(1) : &since_act[b] ? since_act[b] : since_act[b] + 1'b1;
        since_pre[b] <= pre_b[b] ? CNT_W'(1) : &since_pre[b] ? since_pre[b] : since_pre[b] + 1'b1;
      end
    end
  end
  always_comb bank_open_vec = open_q;
`ifdef DDR2_BANK_CHK_FATAL_EN
  always_ff @(posedge clk) begin
    if (!reset && err_now) begin
      $display("%0t ddr2_bank_timing_checker: code=%0d bank=%0d row=%0h", $time, code_d, bank_d, a_pad);
      $fatal(1, "ddr2_bank_timing_checker: timing violation");
    end
  end
`endif
endmodule
